mdu_requester: RTL and testbench

Initiator side of the multiply/divide valid/ready interface. Sits in the CPU execute stage between the pipeline and the MulDivUnit responder. Owns the architectural HI/LO registers, turns MULT/DIV/MFHI/MFLO/MTHI/MTLO requests into responder transactions or register accesses, and stalls the pipeline while a transaction is outstanding.

---
 rtl/mdu_requester.sv | 166 ++++++++++++++++
 tb/tb_mdu_requester.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mdu_requester.sv
`default_nettype none
// ============================================================================
// Module   : mdu_requester
// Brief    : Execute-stage initiator for the MulDivUnit valid/ready interface;
//            owns HI/LO and stalls the pipeline while a MULT/DIV is in flight.
// Config   : MDU_TIMEOUT_EN enables the MAX_WAIT watchdog (sticky timeout_err).
// Revision : 1.0 - initial release
// ============================================================================
module mdu_requester #(
    parameter int MAX_WAIT = 64
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    input  logic [2:0]  req_op,
    input  logic        req_sign,
    input  logic [31:0] req_rs,
    input  logic [31:0] req_rt,
    output logic        req_ready,
    output logic        rd_valid,
    output logic [31:0] rd_data,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy,
    output logic        timeout_err,
    output logic [31:0] mdu_in_src0,
    output logic [31:0] mdu_in_src1,
    output logic [1:0]  mdu_in_op,
    output logic        mdu_in_sign,
    output logic        mdu_in_valid,
    input  logic        mdu_in_ready,
    input  logic        mdu_out_valid,
    output logic        mdu_out_ready,
    input  logic [31:0] mdu_out_res0,
    input  logic [31:0] mdu_out_res1
);

    localparam logic [2:0] c_op_none = 3'd0;
    localparam logic [2:0] c_op_mult = 3'd1;
    localparam logic [2:0] c_op_div  = 3'd2;
    localparam logic [2:0] c_op_mfhi = 3'd3;
    localparam logic [2:0] c_op_mflo = 3'd4;
    localparam logic [2:0] c_op_mthi = 3'd5;
    localparam logic [2:0] c_op_mtlo = 3'd6;
    localparam logic [2:0] c_op_rsvd = 3'd7;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    state_t r_state;
    logic   w_op_none;
    logic   w_accept;
    logic   w_expired;

    assign w_op_none = (req_op == c_op_none) || (req_op == c_op_rsvd);
    assign w_accept  = req_valid && !w_op_none && (r_state == IDLE);
    assign req_ready = !req_valid || w_op_none || (r_state == IDLE);
    assign busy      = (r_state != IDLE);

`ifdef MDU_TIMEOUT_EN
    localparam int c_cnt_w = $clog2(MAX_WAIT + 1);

    logic [c_cnt_w-1:0] r_wait_cnt;
    logic               r_timeout_err;

    // A result arriving on the last allowed cycle still wins over the abort.
    assign w_expired = (r_state != IDLE) &&
                       (r_wait_cnt == c_cnt_w'(MAX_WAIT - 1)) &&
                       !((r_state == WAIT) && mdu_out_valid);
    assign timeout_err = r_timeout_err;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_wait_cnt    <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            if (w_accept)
                r_wait_cnt <= '0;
            else if (r_state != IDLE)
                r_wait_cnt <= r_wait_cnt + 1'b1;
            if (w_expired)
                r_timeout_err <= 1'b1;
        end
    end
`else
    logic w_unused_cfg;

    assign w_unused_cfg = (MAX_WAIT > 0);
    assign w_expired    = 1'b0;
    assign timeout_err  = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state       <= IDLE;
            hi            <= '0;
            lo            <= '0;
            rd_data       <= '0;
            rd_valid      <= 1'b0;
            mdu_in_src0   <= '0;
            mdu_in_src1   <= '0;
            mdu_in_op     <= 2'd0;
            mdu_in_sign   <= 1'b0;
            mdu_in_valid  <= 1'b0;
            mdu_out_ready <= 1'b0;
        end else begin
            rd_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        case (req_op)
                            c_op_mult, c_op_div: begin
                                mdu_in_src0  <= req_rs;
                                mdu_in_src1  <= req_rt;
                                mdu_in_sign  <= req_sign;
                                mdu_in_op    <= (req_op == c_op_mult) ? 2'd1 : 2'd2;
                                mdu_in_valid <= 1'b1;
                                r_state      <= ISSUE;
                            end
                            c_op_mfhi: begin
                                rd_data  <= hi;
                                rd_valid <= 1'b1;
                            end
                            c_op_mflo: begin
                                rd_data  <= lo;
                                rd_valid <= 1'b1;
                            end
                            c_op_mthi: hi <= req_rs;
                            c_op_mtlo: lo <= req_rs;
                            default: ;
                        endcase
                    end
                end
                ISSUE: begin
                    if (w_expired) begin
                        mdu_in_valid <= 1'b0;
                        mdu_in_op    <= 2'd0;
                        r_state      <= IDLE;
                    end else if (mdu_in_valid && mdu_in_ready) begin
                        mdu_in_valid  <= 1'b0;
                        mdu_in_op     <= 2'd0;
                        mdu_out_ready <= 1'b1;
                        r_state       <= WAIT;
                    end
                end
                WAIT: begin
                    if (mdu_out_valid) begin
                        hi            <= mdu_out_res1;
                        lo            <= mdu_out_res0;
                        mdu_out_ready <= 1'b0;
                        r_state       <= IDLE;
                    end else if (w_expired) begin
                        mdu_out_ready <= 1'b0;
                        r_state       <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mdu_requester.sv
`default_nettype none
// ============================================================================
// Module   : tb_mdu_requester
// Brief    : Directed, table-driven bench for mdu_requester with a responder stub.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mdu_requester;

    logic        clock = 1'b0;
    logic        reset;
    logic        req_valid;
    logic [2:0]  req_op;
    logic        req_sign;
    logic [31:0] req_rs, req_rt;
    logic        req_ready, rd_valid, busy, timeout_err;
    logic [31:0] rd_data, hi, lo;
    logic [31:0] mdu_in_src0, mdu_in_src1;
    logic [1:0]  mdu_in_op;
    logic        mdu_in_sign, mdu_in_valid, mdu_in_ready;
    logic        mdu_out_valid, mdu_out_ready;
    logic [31:0] mdu_out_res0, mdu_out_res1;

    mdu_requester #(.MAX_WAIT(8)) dut (
        .clock         (clock),
        .reset         (reset),
        .req_valid     (req_valid),
        .req_op        (req_op),
        .req_sign      (req_sign),
        .req_rs        (req_rs),
        .req_rt        (req_rt),
        .req_ready     (req_ready),
        .rd_valid      (rd_valid),
        .rd_data       (rd_data),
        .hi            (hi),
        .lo            (lo),
        .busy          (busy),
        .timeout_err   (timeout_err),
        .mdu_in_src0   (mdu_in_src0),
        .mdu_in_src1   (mdu_in_src1),
        .mdu_in_op     (mdu_in_op),
        .mdu_in_sign   (mdu_in_sign),
        .mdu_in_valid  (mdu_in_valid),
        .mdu_in_ready  (mdu_in_ready),
        .mdu_out_valid (mdu_out_valid),
        .mdu_out_ready (mdu_out_ready),
        .mdu_out_res0  (mdu_out_res0),
        .mdu_out_res1  (mdu_out_res1)
    );

    always #5 clock = ~clock;

    // Responder stub: one cycle from accepted request to result; stall mode never answers.
    logic stub_stall = 1'b0;
    int   hs_count   = 0;

    function automatic logic [63:0] resp(input logic [1:0] op, input logic s,
                                         input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        logic [31:0] q, r;
        if (op == 2'd1) begin
            if (s) p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
            else   p = {32'b0, a} * {32'b0, b};
            return p;
        end
        if (b == 32'd0) begin
            q = '1; r = a;
        end else if (s) begin
            q = $signed(a) / $signed(b); r = $signed(a) % $signed(b);
        end else begin
            q = a / b; r = a % b;
        end
        return {r, q};
    endfunction

    assign mdu_in_ready = !mdu_out_valid;

    always @(posedge clock) begin
        if (reset) begin
            mdu_out_valid <= 1'b0;
            mdu_out_res0  <= '0;
            mdu_out_res1  <= '0;
        end else if (mdu_out_valid && mdu_out_ready) begin
            mdu_out_valid <= 1'b0;
        end else if (mdu_in_valid && mdu_in_ready) begin
            hs_count <= hs_count + 1;
            {mdu_out_res1, mdu_out_res0} <= resp(mdu_in_op, mdu_in_sign, mdu_in_src0, mdu_in_src1);
            if (!stub_stall) mdu_out_valid <= 1'b1;
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [2:0]  op;
        logic        sign;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
        logic        exp_rdv;
        logic [31:0] exp_rd;
        int          exp_lat;
    } vec_t;

    vec_t vecs[11];

    task automatic apply(input int idx, input vec_t v);
        int n;
        @(negedge clock);
        req_valid = 1'b1; req_op = v.op; req_sign = v.sign; req_rs = v.rs; req_rt = v.rt;
        #1 chk($sformatf("v%0d_ready", idx), req_ready, 1'b1);
        @(negedge clock);
        req_valid = 1'b0; req_op = 3'd0;
        chk($sformatf("v%0d_rd_valid", idx), rd_valid, v.exp_rdv);
        if (v.exp_rdv) chk($sformatf("v%0d_rd_data", idx), rd_data, v.exp_rd);
        n = 0;
        while (busy && n < 50) begin
            @(negedge clock);
            n++;
        end
        chk($sformatf("v%0d_latency", idx), n, v.exp_lat);
        chk($sformatf("v%0d_hi", idx), hi, v.exp_hi);
        chk($sformatf("v%0d_lo", idx), lo, v.exp_lo);
        @(negedge clock);
        chk($sformatf("v%0d_rd_valid_drop", idx), rd_valid, 1'b0);
        chk($sformatf("v%0d_in_valid_idle", idx), mdu_in_valid, 1'b0);
        chk($sformatf("v%0d_in_op_idle", idx), mdu_in_op, 2'd0);
    endtask

    int n;
    int hs_before;

    initial begin
        reset = 1'b1; req_valid = 1'b0; req_op = 3'd0; req_sign = 1'b0; req_rs = '0; req_rt = '0;

        //           op    sgn   rs            rt            exp_hi        exp_lo        rdv   rd            lat
        vecs[0]  = '{3'd5, 1'b0, 32'hAAAA5555, 32'h0,        32'hAAAA5555, 32'h00000000, 1'b0, 32'h0,        0};
        vecs[1]  = '{3'd6, 1'b0, 32'h12345678, 32'h0,        32'hAAAA5555, 32'h12345678, 1'b0, 32'h0,        0};
        vecs[2]  = '{3'd4, 1'b0, 32'h0,        32'h0,        32'hAAAA5555, 32'h12345678, 1'b1, 32'h12345678, 0};
        vecs[3]  = '{3'd3, 1'b0, 32'h0,        32'h0,        32'hAAAA5555, 32'h12345678, 1'b1, 32'hAAAA5555, 0};
        vecs[4]  = '{3'd1, 1'b1, 32'hFFFFFFFD, 32'h5,        32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0, 32'h0,        2};
        vecs[5]  = '{3'd2, 1'b0, 32'd100,      32'd7,        32'h00000002, 32'h0000000E, 1'b0, 32'h0,        2};
        vecs[6]  = '{3'd2, 1'b1, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 32'h0,        2};
        vecs[7]  = '{3'd1, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, 32'h0,        2};
        vecs[8]  = '{3'd1, 1'b0, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000, 1'b0, 32'h0,        2};
        vecs[9]  = '{3'd7, 1'b0, 32'hDEADBEEF, 32'h1,        32'h00000001, 32'h00000000, 1'b0, 32'h0,        0};
        vecs[10] = '{3'd3, 1'b0, 32'h0,        32'h0,        32'h00000001, 32'h00000000, 1'b1, 32'h00000001, 0};

        repeat (2) @(negedge clock);
        chk("rst_hi", hi, 32'h0);
        chk("rst_lo", lo, 32'h0);
        chk("rst_rd_data", rd_data, 32'h0);
        chk("rst_src0", mdu_in_src0, 32'h0);
        chk("rst_src1", mdu_in_src1, 32'h0);
        chk("rst_in_op", mdu_in_op, 2'd0);
        chk("rst_in_sign", mdu_in_sign, 1'b0);
        chk("rst_in_valid", mdu_in_valid, 1'b0);
        chk("rst_out_ready", mdu_out_ready, 1'b0);
        chk("rst_rd_valid", rd_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_timeout", timeout_err, 1'b0);
        reset = 1'b0;

        for (int i = 0; i < 11; i++) apply(i, vecs[i]);
        chk("handshakes_after_table", hs_count, 5);

        // MFHI held stable while an unsigned DIV 50/8 is in flight
        @(negedge clock);
        req_valid = 1'b1; req_op = 3'd2; req_sign = 1'b0; req_rs = 32'd50; req_rt = 32'd8;
        #1 chk("div_accept", req_ready, 1'b1);
        @(negedge clock);
        req_op = 3'd3; req_rs = '0; req_rt = '0;
        #1 chk("mfhi_stall_issue", req_ready, 1'b0);
        chk("issue_in_valid", mdu_in_valid, 1'b1);
        chk("issue_in_op", mdu_in_op, 2'd2);
        chk("issue_src0", mdu_in_src0, 32'd50);
        chk("issue_src1", mdu_in_src1, 32'd8);
        @(negedge clock);
        #1 chk("mfhi_stall_wait", req_ready, 1'b0);
        chk("wait_out_ready", mdu_out_ready, 1'b1);
        chk("wait_in_valid", mdu_in_valid, 1'b0);
        chk("wait_in_op", mdu_in_op, 2'd0);
        chk("wait_rd_valid", rd_valid, 1'b0);
        @(negedge clock);
        #1 chk("mfhi_ready_idle", req_ready, 1'b1);
        chk("div_busy_drop", busy, 1'b0);
        chk("div_hi", hi, 32'd2);
        chk("div_lo", lo, 32'd6);
        @(negedge clock);
        req_valid = 1'b0; req_op = 3'd0;
        chk("held_mfhi_rd_valid", rd_valid, 1'b1);
        chk("held_mfhi_rd_data", rd_data, 32'd2);

        // Back-to-back MTHI then MFHI
        hs_before = hs_count;
        @(negedge clock);
        req_valid = 1'b1; req_op = 3'd5; req_rs = 32'hCAFEBABE;
        @(negedge clock);
        req_op = 3'd3; req_rs = '0;
        #1 chk("b2b_ready", req_ready, 1'b1);
        @(negedge clock);
        req_valid = 1'b0; req_op = 3'd0;
        chk("b2b_rd_valid", rd_valid, 1'b1);
        chk("b2b_rd_data", rd_data, 32'hCAFEBABE);
        @(negedge clock);
        chk("b2b_rd_pulse", rd_valid, 1'b0);
        chk("b2b_no_traffic", hs_count, hs_before);

        // Reset in the middle of a MULT
        @(negedge clock);
        req_valid = 1'b1; req_op = 3'd1; req_sign = 1'b1; req_rs = 32'd3; req_rt = 32'd4;
        @(negedge clock);
        req_valid = 1'b0; req_op = 3'd0;
        chk("midrst_busy_before", busy, 1'b1);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_in_valid", mdu_in_valid, 1'b0);
        chk("midrst_hi", hi, 32'h0);
        repeat (3) @(negedge clock);
        chk("midrst_lo_late", lo, 32'h0);
        chk("midrst_hi_late", hi, 32'h0);

        // Responder that never answers
        @(negedge clock);
        req_valid = 1'b1; req_op = 3'd5; req_rs = 32'h5A5A5A5A;
        @(negedge clock);
        stub_stall = 1'b1;
        req_op = 3'd1; req_sign = 1'b0; req_rs = 32'd9; req_rt = 32'd9;
        @(negedge clock);
        req_valid = 1'b0; req_op = 3'd0;
        n = 0;
        while (busy && n < 40) begin
            @(negedge clock);
            n++;
        end
`ifdef MDU_TIMEOUT_EN
        chk("to_cycles", n, 8);
        chk("to_err", timeout_err, 1'b1);
        chk("to_hi", hi, 32'h5A5A5A5A);
        chk("to_lo", lo, 32'h0);
        chk("to_in_valid", mdu_in_valid, 1'b0);
        chk("to_out_ready", mdu_out_ready, 1'b0);
        repeat (2) @(negedge clock);
        chk("to_err_sticky", timeout_err, 1'b1);
`else
        chk("stall_still_busy", n, 40);
        chk("stall_no_timeout", timeout_err, 1'b0);
        chk("stall_out_ready", mdu_out_ready, 1'b1);
        chk("stall_hi", hi, 32'h5A5A5A5A);
`endif
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        stub_stall = 1'b0;
        chk("post_rst_err", timeout_err, 1'b0);
        chk("post_rst_busy", busy, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
